// File: rtl/arquitetura_robot_command_out.sv
// Avalon-MM command output port: holds a written command for HOLD clocks, then auto-clears it.
// Optional readback of DATA/HOLD is built only when ROBOT_CMD_READBACK_EN is defined.
module arquitetura_robot_command_out #(
    parameter int          WIDTH       = 4,
    parameter int          HOLD_W      = 24,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_HOLD   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0]  data_reg, data_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [HOLD_W-1:0] count_reg, count_next;
    logic              active_reg, active_next;
    logic              expired_reg, expired_next;
    logic [31:0]       readdata_reg, readdata_next;

    logic              write_en;
    logic              restart;
    logic              expire;
    logic [WIDTH-1:0]  wd_data;
    logic              unused_wd;

    assign write_en  = chipselect & ~write_n;
    assign wd_data   = writedata[WIDTH-1:0];
    assign restart   = write_en && (address == ADDR_DATA || address == ADDR_OUTSET);
    assign expire    = (count_reg == HOLD_W'(1));
    assign unused_wd = ^writedata;

    always_comb begin
        data_next    = data_reg;
        hold_next    = hold_reg;
        count_next   = count_reg;
        active_next  = active_reg;
        expired_next = expired_reg;

        if (write_en && address == ADDR_HOLD)
            hold_next = writedata[HOLD_W-1:0];

        // Clear first so that an expiry on the same cycle re-sets the flag.
        if (write_en && address == ADDR_STATUS && writedata[1])
            expired_next = 1'b0;

        if (restart) begin
            data_next   = (address == ADDR_DATA) ? wd_data : (data_reg | wd_data);
            count_next  = hold_reg;
            active_next = (hold_reg != '0);
        end else if (expire) begin
            data_next    = '0;
            count_next   = '0;
            active_next  = 1'b0;
            expired_next = 1'b1;
        end else begin
            if (count_reg != '0)
                count_next = count_reg - HOLD_W'(1);
            if (write_en && address == ADDR_OUTCLR)
                data_next = data_reg & ~wd_data;
        end
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_STATUS: readdata_next = {30'd0, expired_reg, active_reg};
`ifdef ROBOT_CMD_READBACK_EN
            ADDR_DATA:   readdata_next = 32'(data_reg);
            ADDR_HOLD:   readdata_next = 32'(hold_reg);
`endif
            default:     readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg     <= RST_DATA;
            hold_reg     <= '0;
            count_reg    <= '0;
            active_reg   <= 1'b0;
            expired_reg  <= 1'b0;
            readdata_reg <= '0;
        end else begin
            data_reg     <= data_next;
            hold_reg     <= hold_next;
            count_reg    <= count_next;
            active_reg   <= active_next;
            expired_reg  <= expired_next;
            readdata_reg <= readdata_next;
        end
    end

    assign out_port = data_reg;
    assign readdata = readdata_reg;

endmodule

// File: tb/tb_arquitetura_robot_command_out.sv
// Directed bench for arquitetura_robot_command_out: hold timer, OUTSET/OUTCLR, expiry races, reset, readback.
module tb_arquitetura_robot_command_out;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int tests = 0;
    int fails = 0;

    arquitetura_robot_command_out #(
        .WIDTH(4),
        .HOLD_W(24),
        .RESET_VALUE(32'd0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // All helpers start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[TB] write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        d          = readdata;
        chipselect = 1'b0;
        $display("[TB] read  addr=%0d data=0x%08h", a, d);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_data_rb;
    logic [31:0] exp_hold_rb;
    logic        stayed;

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // Reset state
        address = 3'd2;
        step();
        step();
        check("reset_out_port", 32'(out_port), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        stayed = 1'b1;
        repeat (10) begin
            step();
            if (out_port !== 4'h0 || readdata !== 32'h0) stayed = 1'b0;
        end
        check("idle_after_reset", 32'(stayed), 32'h1);
        bus_read(3'd2, rd);
        check("reset_status", rd, 32'h0);

        // Hold forever
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'hA);
        check("hold0_out_next", 32'(out_port), 32'hA);
        stayed = 1'b1;
        repeat (1000) begin
            step();
            if (out_port !== 4'hA) stayed = 1'b0;
        end
        check("hold0_stays_1000", 32'(stayed), 32'h1);
        bus_read(3'd2, rd);
        check("hold0_status_idle", rd, 32'h0);

        // Hold for 5 cycles
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'h3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold5_cycle%0d", i), 32'(out_port), 32'h3);
            step();
        end
        check("hold5_cleared", 32'(out_port), 32'h0);
        bus_read(3'd2, rd);
        check("hold5_status_expired", rd, 32'h2);
        bus_write(3'd2, 32'h2);
        bus_read(3'd2, rd);
        check("w1c_clears_expired", rd, 32'h0);

        // OUTSET restarts timer, OUTCLR leaves it
        bus_write(3'd1, 32'd8);
        bus_write(3'd0, 32'h1);
        step();
        step();
        bus_write(3'd4, 32'h4);
        check("outset_or", 32'(out_port), 32'h5);
        step();
        step();
        bus_write(3'd5, 32'h1);
        check("outclr_andnot", 32'(out_port), 32'h4);
        repeat (4) step();
        check("outset_restart_holds", 32'(out_port), 32'h4);
        step();
        check("outset_clear_at_8", 32'(out_port), 32'h0);
        bus_read(3'd2, rd);
        check("outset_status_expired", rd, 32'h2);
        bus_write(3'd2, 32'h2);

        // DATA write on exact expiry cycle
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'h2);
        repeat (3) step();
        bus_write(3'd0, 32'h6);
        check("race_write_wins", 32'(out_port), 32'h6);
        bus_read(3'd2, rd);
        check("race_status_active_only", rd, 32'h1);
        step();
        step();
        check("race_still_held", 32'(out_port), 32'h6);
        step();
        check("race_cleared_4_later", 32'(out_port), 32'h0);
        bus_read(3'd2, rd);
        check("race_status_expired", rd, 32'h2);

        // Reset mid-countdown
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, 32'h7);
        step();
        check("pre_reset_out", 32'(out_port), 32'h7);
        reset_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out_port), 32'h0);
        check("async_reset_readdata", readdata, 32'h0);
        step();
        reset_n = 1'b1;
        repeat (6) step();
        bus_read(3'd2, rd);
        check("reset_no_expired", rd, 32'h0);

        // Readback and ignored addresses
`ifdef ROBOT_CMD_READBACK_EN
        exp_data_rb = 32'h9;
        exp_hold_rb = 32'h123;
`else
        exp_data_rb = 32'h0;
        exp_hold_rb = 32'h0;
`endif
        bus_write(3'd0, 32'h9);
        bus_read(3'd0, rd);
        check("readback_data", rd, exp_data_rb);
        bus_write(3'd1, 32'h123);
        bus_read(3'd1, rd);
        check("readback_hold", rd, exp_hold_rb);
        bus_write(3'd3, 32'hF);
        bus_write(3'd6, 32'hF);
        bus_write(3'd7, 32'hF);
        check("ignored_addr_writes", 32'(out_port), 32'h9);
        bus_read(3'd7, rd);
        check("addr7_reads_zero", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
